ripple_accumulator: RTL and testbench
=====================================

# ripple_accumulator

Frame accumulator sitting directly downstream of `ripple_carry_adder`. It instantiates the adder with `a` = running accumulator and `b` = incoming sample. It registers `{cout, sum}` on every accepted sample. After `COUNT` samples it presents the N-bit modular total and a sticky overflow flag on a valid/ready output. It is the first sequential consumer of the adder, turning a combinational add into a handshaked, multi-cycle reduction.

## Interface
Parameters:
- `N`, default 4: sample/accumulator width; passed to the adder as `n`.
- `COUNT`, default 4: samples per frame, ≥1. Counter width is max(1, $clog2(COUNT)).

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `clear`, in, 1: synchronous frame abort, highest priority after reset.
- `in_valid`, in, 1: upstream sample valid.
- `in_ready`, out, 1: block can accept a sample.
- `in_data`, in, N: sample, unsigned.
- `out_valid`, out, 1: frame result valid.
- `out_ready`, in, 1: downstream accepts result.
- `out_sum`, out, N: frame total modulo 2^N.
- `out_ovf`, out, 1: at least one adder carry-out occurred in the frame.

## Operation
- State: `ACC` (accepting) and `HOLD` (result presented). Registers are `state`, `acc`[N], `cnt`, `ovf`, `out_sum`, `out_ovf`.
- Adder hookup: `a = acc`, `b = in_data`. `sum`/`cout` are used only on an accept cycle.
- `in_ready = (state == ACC)` (combinational from state only). `out_valid = (state == HOLD)`.
- Accept occurs when `in_valid && in_ready && !clear`. On accept:
  - `acc <= sum`, `ovf <= ovf | cout`.
  - If `cnt == COUNT-1`: go to HOLD; `out_sum <= sum`; `out_ovf <= ovf | cout`; `cnt`, `acc`, `ovf` reset to 0.
  - Else `cnt <= cnt + 1`.
- In `ACC` without accept: all state holds, so input bubbles do not count.
- In `HOLD`: `out_sum`/`out_ovf` are stable and `in_valid` is ignored. On `out_ready`, go to `ACC` next cycle.
- `clear` (any state): next cycle state = `ACC` and `acc`, `cnt`, `ovf` = 0. `out_valid` drops and any pending result is discarded. A sample presented in the same cycle is not accepted.
- Arithmetic: unsigned and wraps modulo 2^N. The overflow flag is sticky per frame and cleared at frame start.
- Reset (`rst_n` low, any time including mid-frame or in `HOLD`): state immediately `ACC`, `acc`=0, `cnt`=0, `ovf`=0, `out_sum`=0, `out_ovf`=0.
  - Resulting output values: `out_valid`=0, `in_ready`=1.
  - Handshakes while `rst_n` is low are void.

## Timing
- Input accept: zero-latency handshake; sample consumed on the edge where `in_valid && in_ready`.
- Result: `out_valid` rises the cycle after the COUNT-th accept.
- Output transfer completes on the edge where `out_valid && out_ready`. `in_ready` rises the following cycle.
- No bypass: `in_ready` is 0 for every `HOLD` cycle. Peak throughput is one frame per COUNT+1 cycles.
- `out_sum`/`out_ovf` change only on the COUNT-th accept, `clear`, or reset. They are never changed while `out_valid` = 1 and not handshaken.
- COUNT=1: every accept goes straight to `HOLD` with `out_sum = in_data` and `out_ovf = 0`.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation. Required: immediately `out_valid`=0, `out_sum`=0, `out_ovf`=0, `in_ready`=1. After release, first frame 1,1,1,1 gives `out_sum`=4.
- Back-to-back frame (N=4, COUNT=4), samples 1,2,3,4 with `out_ready`=1. Required: `out_valid` for exactly 1 cycle, the cycle after the 4th accept, with `out_sum`=10 and `out_ovf`=0. `in_ready`=0 in that cycle.
- Overflow: samples 15,15,1,0. Required: `out_sum`=15 (31 mod 16) and `out_ovf`=1. The next frame 0,0,0,0 gives `out_sum`=0 and `out_ovf`=0.
- Backpressure and bubbles: samples 2,_,3,_,_,4,5 with `in_valid` gaps, then `out_ready`=0 for 5 cycles while `in_valid`=1, `in_data`=7. Required:
  - `out_sum`=14, held stable and valid for all 5 cycles.
  - No sample accepted during the stall.
  - After `out_ready`, the next frame starts from 0.
- Clear: accept 9,9 (carry set), pulse `clear` with `in_valid`=1, `in_data`=5, then send 1,2,3,4. Required: the 5 is not accepted and `out_sum`=10 with `out_ovf`=0. A `clear` in `HOLD` drops `out_valid` next cycle with no transfer.
- Random: 200 frames of random `in_valid`/`out_ready`/`in_data`, checked against a scoreboard model of modular sum and OR of carries. Required: zero mismatches, no lost or duplicated frames.

Source files
------------

// File: rtl/ripple_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : ripple_accumulator_if
// Description : Bus bundle for the frame accumulator. It carries the sample
//               stream (valid/ready), the result stream (valid/ready) and the
//               synchronous frame-abort strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface ripple_accumulator_if #(
  parameter int N = 4
);
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_ovf;

  // Producer/consumer side, which drives samples and accepts results
  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  // Accumulator side
  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/ripple_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder / ripple_accumulator
// Description : The unsigned ripple-carry adder, and a handshaked frame
//               accumulator built on it. The accumulator sums COUNT samples
//               modulo 2^N, tracks whether any carry-out occurred in the frame,
//               and holds the result on a valid/ready port until it is taken.
// Revision    : 1.0 - initial release
// ============================================================================

module ripple_carry_adder #(
  parameter int n = 4
) (
  input  wire logic [n-1:0] a,
  input  wire logic [n-1:0] b,
  output      logic [n-1:0] sum,
  output      logic         cout
);
  // Carry chain; bit 0 has no carry-in
  logic [n:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < n; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[n];
endmodule

module ripple_accumulator #(
  parameter int N     = 4,
  parameter int COUNT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  ripple_accumulator_if.slave    acc_bus
);
  // A counter of at least one bit keeps COUNT=1 legal
  localparam int            CW     = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(COUNT - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic [N-1:0]  r_out_sum;
  logic          r_out_ovf;

  logic [N-1:0]  w_sum;
  logic          w_cout;

  // Running total plus the incoming sample
  ripple_carry_adder #(
    .n (N)
  ) u_adder (
    .a    (r_acc),
    .b    (acc_bus.in_data),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Handshake flags depend only on the state register, so there is no
  // combinational path from out_ready to in_ready (no bypass).
  assign acc_bus.in_ready  = (r_state == ST_ACC);
  assign acc_bus.out_valid = (r_state == ST_HOLD);
  assign acc_bus.out_sum   = r_out_sum;
  assign acc_bus.out_ovf   = r_out_ovf;

  // Frame FSM: accumulate in ACC, present the result in HOLD; clear aborts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_sum <= '0;
      r_out_ovf <= 1'b0;
    end else if (acc_bus.clear) begin
      // Abort: drop any pending result and any partial frame; a sample
      // offered this cycle is not consumed.
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (acc_bus.in_valid) begin
            if (r_cnt == C_LAST) begin
              // Last sample: publish the total and restart the frame
              r_state   <= ST_HOLD;
              r_out_sum <= w_sum;
              r_out_ovf <= r_ovf | w_cout;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_ovf     <= 1'b0;
            end else begin
              r_acc <= w_sum;
              r_ovf <= r_ovf | w_cout;
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (acc_bus.out_ready) begin
            r_state <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ripple_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_accumulator
// Description : Directed and random stimulus for ripple_accumulator (N=4,
//               COUNT=4). Expected frame results go into a queue when the
//               stimulus is issued; an independent monitor pops and compares
//               them whenever a result transfer takes place.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_accumulator;
  localparam int N     = 4;
  localparam int COUNT = 4;

  logic clk;
  logic rst_n;

  ripple_accumulator_if #(.N(N)) bus ();

  ripple_accumulator #(
    .N     (N),
    .COUNT (COUNT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_exp  = 0;  // frames expected to be transferred
  int n_xfer = 0;  // frames actually transferred

  // {ovf, sum}
  logic [N:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input int s, input int o);
    exp_q.push_back({o[0], s[N-1:0]});
    n_exp++;
  endtask

  // ---------------- monitor ----------------
  logic       prev_hold = 1'b0;
  logic [N-1:0] prev_sum;
  logic       prev_ovf;
  logic       xfer;
  logic [N:0] e;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_vs_out_valid", int'(bus.in_ready), int'(!bus.out_valid));
      if (prev_hold && bus.out_valid) begin
        chk("hold_sum_stable", int'(bus.out_sum), int'(prev_sum));
        chk("hold_ovf_stable", int'(bus.out_ovf), int'(prev_ovf));
      end
      xfer = bus.out_valid && bus.out_ready && !bus.clear;
      if (xfer) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_sum", int'(bus.out_sum), int'(e[N-1:0]));
          chk("frame_ovf", int'(bus.out_ovf), int'(e[N]));
        end
      end
      prev_hold = bus.out_valid && !xfer && !bus.clear;
      prev_sum  = bus.out_sum;
      prev_ovf  = bus.out_ovf;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offer one sample and wait (bounded) until it is consumed
  task automatic send(input int d);
    int  t  = 0;
    logic ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d[N-1:0];
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = bus.in_ready && !bus.clear;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: sample %0d not accepted, got in_ready=0 expected 1", d);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  // ---------------- main sequence ----------------
  int   rn, cyc, wt;
  int   m_cnt;
  logic [N-1:0] m_acc;
  logic       m_ovf;
  logic [N:0] m_s;

  initial begin
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("por_out_valid", int'(bus.out_valid), 0);
    chk("por_in_ready",  int'(bus.in_ready), 1);
    chk("por_out_sum",   int'(bus.out_sum), 0);
    rst_n = 1'b1;
    idle(1);

    // Reset while a result is held: outputs return to reset values at once
    bus.out_ready = 1'b0;
    send4(1, 2, 3, 4);
    @(negedge clk);
    chk("pre_reset_valid", int'(bus.out_valid), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum",   int'(bus.out_sum), 0);
    chk("rst_out_ovf",   int'(bus.out_ovf), 0);
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    expect_frame(4, 0);
    send4(1, 1, 1, 1);
    idle(2);

    // Back-to-back frame: result valid for exactly one cycle
    expect_frame(10, 0);
    send4(1, 2, 3, 4);
    @(negedge clk);
    chk("b2b_valid_cycle1", int'(bus.out_valid), 1);
    chk("b2b_in_ready_low", int'(bus.in_ready), 0);
    chk("b2b_sum",          int'(bus.out_sum), 10);
    @(negedge clk);
    chk("b2b_valid_cycle2", int'(bus.out_valid), 0);
    @(posedge clk); #1;

    // Overflow frame then an all-zero frame
    expect_frame(15, 1);
    send4(15, 15, 1, 0);
    expect_frame(0, 0);
    send4(0, 0, 0, 0);
    idle(2);

    // Bubbles, then a 5-cycle stall with a sample waiting upstream
    bus.out_ready = 1'b0;
    expect_frame(14, 0);
    send(2); idle(1); send(3); idle(2); send(4); send(5);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid",    int'(bus.out_valid), 1);
      chk("stall_sum",      int'(bus.out_sum), 14);
      chk("stall_in_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    expect_frame(4, 0);
    send4(1, 1, 1, 1);
    idle(2);

    // Clear mid-frame discards partial sum, carry and the concurrent sample
    send(9); send(9);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd5;
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    expect_frame(10, 0);
    send4(1, 2, 3, 4);
    idle(2);

    // Clear while a result is held: no transfer, out_valid drops
    bus.out_ready = 1'b0;
    send4(1, 1, 1, 1);
    @(negedge clk);
    chk("clr_hold_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    bus.clear     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    @(negedge clk);
    chk("clr_hold_dropped", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    idle(2);

    // Random frames against a modular-sum / OR-of-carries model
    rn = 0; cyc = 0; m_cnt = 0; m_acc = '0; m_ovf = 1'b0;
    while (rn < 200 && cyc < 20000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = N'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        m_s   = {1'b0, m_acc} + {1'b0, bus.in_data};
        m_acc = m_s[N-1:0];
        m_ovf = m_ovf | m_s[N];
        m_cnt++;
        if (m_cnt == COUNT) begin
          expect_frame(int'(m_acc), int'(m_ovf));
          rn++;
          m_cnt = 0; m_acc = '0; m_ovf = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_frames_issued", rn, 200);
    wt = 0;
    while (exp_q.size() != 0 && wt < 20) begin
      @(posedge clk); #1;
      wt++;
    end
    idle(2);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_count", n_xfer, n_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
